// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters, registered prediction
// response and registered mispredict/redirect pulse. Define BRANCH_PREDICTOR_STATS_EN for stat counters.
module branch_predictor #(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int ENTRIES     = 16,
  localparam int INDEX_WIDTH = $clog2(ENTRIES),
  localparam int OP_WIDTH    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pred_valid,
  input  logic [ADDR_WIDTH-1:0] i_pred_pc,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  input  logic                  i_res_valid,
  input  logic [ADDR_WIDTH-1:0] i_res_pc,
  input  logic [OP_WIDTH-1:0]   i_res_op,
  input  logic                  i_res_taken,
  input  logic                  i_res_pred_taken,
  output logic                  o_mispredict,
  output logic                  o_redirect_taken
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispredicts
`endif
);

  logic [1:0]             cnt_q [ENTRIES];
  logic [1:0]             cnt_d [ENTRIES];
  logic [INDEX_WIDTH-1:0] pred_idx;
  logic [INDEX_WIDTH-1:0] res_idx;
  logic                   res_counted;
  logic                   pred_valid_q, pred_valid_d;
  logic                   pred_taken_q, pred_taken_d;
  logic                   mispredict_q, mispredict_d;
  logic                   redirect_taken_q, redirect_taken_d;
  logic                   unused_pc_bits;

  assign pred_idx       = i_pred_pc[INDEX_WIDTH+1:2];
  assign res_idx        = i_res_pc[INDEX_WIDTH+1:2];
  assign res_counted    = i_res_valid && (i_res_op != '0);
  assign unused_pc_bits = ^{i_pred_pc, i_res_pc};

  always_comb begin
    cnt_d = cnt_q;
    if (res_counted) begin
      if (i_res_taken) begin
        if (cnt_q[res_idx] != 2'b11) cnt_d[res_idx] = cnt_q[res_idx] + 2'd1;
      end else begin
        if (cnt_q[res_idx] != 2'b00) cnt_d[res_idx] = cnt_q[res_idx] - 2'd1;
      end
    end
    // Prediction reads the pre-update table, giving read-before-write on index collisions.
    pred_valid_d     = i_pred_valid;
    pred_taken_d     = i_pred_valid & cnt_q[pred_idx][1];
    mispredict_d     = res_counted & (i_res_taken ^ i_res_pred_taken);
    redirect_taken_d = mispredict_d & i_res_taken;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q            <= '{default: 2'b01};
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      mispredict_q     <= 1'b0;
      redirect_taken_q <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      pred_valid_q     <= pred_valid_d;
      pred_taken_q     <= pred_taken_d;
      mispredict_q     <= mispredict_d;
      redirect_taken_q <= redirect_taken_d;
    end
  end

  assign o_pred_valid     = pred_valid_q;
  assign o_pred_taken     = pred_taken_q;
  // A pulse already in flight when reset arrives is suppressed rather than leaking out.
  assign o_mispredict     = mispredict_q & ~i_rst;
  assign o_redirect_taken = redirect_taken_q & ~i_rst;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q + 32'(res_counted);
    stat_mispredicts_d = stat_mispredicts_q + 32'(mispredict_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign o_stat_branches    = stat_branches_q;
  assign o_stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// checked against a behavioural counter-table model.
module tb_branch_predictor;
  localparam int AW = 32;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pred_valid;
  logic [AW-1:0] pred_pc;
  logic          o_pred_valid, o_pred_taken;
  logic          res_valid;
  logic [AW-1:0] res_pc;
  logic [1:0]    res_op;
  logic          res_taken, res_pred_taken;
  logic          o_mispredict, o_redirect_taken;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0]   o_stat_branches, o_stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_WIDTH(AW), .ENTRIES(N)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pred_valid     (pred_valid),
    .i_pred_pc        (pred_pc),
    .o_pred_valid     (o_pred_valid),
    .o_pred_taken     (o_pred_taken),
    .i_res_valid      (res_valid),
    .i_res_pc         (res_pc),
    .i_res_op         (res_op),
    .i_res_taken      (res_taken),
    .i_res_pred_taken (res_pred_taken),
    .o_mispredict     (o_mispredict),
    .o_redirect_taken (o_redirect_taken)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .o_stat_branches    (o_stat_branches),
    .o_stat_mispredicts (o_stat_mispredicts)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ctr [N];
  int unsigned m_branches   = 0;
  int unsigned m_mispredicts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int slot(input logic [AW-1:0] pc);
    return int'((pc / 4) % N);
  endfunction

  task automatic idle();
    pred_valid = 0; pred_pc = '0;
    res_valid = 0; res_pc = '0; res_op = 2'b00; res_taken = 0; res_pred_taken = 0;
  endtask

  // Apply the currently driven inputs for one clock edge and check against the model.
  task automatic step();
    int  ri;
    logic e_pv, e_pt, e_mp, e_rd;
    e_pv = 0; e_pt = 0; e_mp = 0; e_rd = 0;
    if (rst) begin
      for (int i = 0; i < N; i++) ctr[i] = 1;
      m_branches = 0; m_mispredicts = 0;
    end else begin
      e_pv = pred_valid;
      e_pt = pred_valid && (ctr[slot(pred_pc)] >= 2);
      if (res_valid && res_op != 2'b00) begin
        ri = slot(res_pc);
        ctr[ri] = res_taken ? ((ctr[ri] < 3) ? ctr[ri] + 1 : 3)
                            : ((ctr[ri] > 0) ? ctr[ri] - 1 : 0);
        e_mp = (res_taken != res_pred_taken);
        e_rd = e_mp && res_taken;
        m_branches++;
        if (e_mp) m_mispredicts++;
      end
    end
    @(posedge clk); #1;
    check("pred_valid", 32'(o_pred_valid), 32'(e_pv));
    check("pred_taken", 32'(o_pred_taken), 32'(e_pt));
    check("mispredict", 32'(o_mispredict), 32'(e_mp));
    check("redirect_taken", 32'(o_redirect_taken), 32'(e_rd));
`ifdef BRANCH_PREDICTOR_STATS_EN
    check("stat_branches", o_stat_branches, m_branches);
    check("stat_mispredicts", o_stat_mispredicts, m_mispredicts);
`endif
  endtask

  task automatic predict(input logic [AW-1:0] pc);
    idle(); pred_valid = 1; pred_pc = pc; step();
  endtask

  task automatic resolve(input logic [AW-1:0] pc, input logic [1:0] op, input logic tk, input logic ptk);
    idle(); res_valid = 1; res_pc = pc; res_op = op; res_taken = tk; res_pred_taken = ptk; step();
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    rst = 0;
    check("reset_pred_valid", 32'(o_pred_valid), 32'd0);
    check("reset_mispredict", 32'(o_mispredict), 32'd0);

    predict(32'h40);
    check("post_reset_valid", 32'(o_pred_valid), 32'd1);
    check("post_reset_taken", 32'(o_pred_taken), 32'd0);
    idle(); step();
    check("idle_valid", 32'(o_pred_valid), 32'd0);

    resolve(32'h40, 2'b01, 1, 0);
    resolve(32'h40, 2'b01, 1, 0);
    predict(32'h40);
    check("trained_taken", 32'(o_pred_taken), 32'd1);
    resolve(32'h40, 2'b01, 1, 1);
    resolve(32'h40, 2'b01, 1, 1);
    resolve(32'h40, 2'b01, 0, 1);
    resolve(32'h40, 2'b01, 0, 1);
    predict(32'h40);
    check("saturated_then_two_down", 32'(o_pred_taken), 32'd0);
    predict(32'hFFF0_0040);
    check("alias_entry", 32'(o_pred_taken), 32'd0);

    resolve(32'h44, 2'b10, 1, 0);
    check("mispredict_pulse", 32'(o_mispredict), 32'd1);
    check("mispredict_redirect", 32'(o_redirect_taken), 32'd1);
    idle(); step();
    check("mispredict_one_cycle", 32'(o_mispredict), 32'd0);

    resolve(32'h4C, 2'b00, 1, 0);
    check("nop_no_mispredict", 32'(o_mispredict), 32'd0);
    resolve(32'h4C, 2'b01, 1, 1);
    predict(32'h4C);
    check("nop_counter_unchanged", 32'(o_pred_taken), 32'd1);

    idle();
    pred_valid = 1; pred_pc = 32'h48;
    res_valid = 1; res_pc = 32'h48; res_op = 2'b11; res_taken = 1; res_pred_taken = 1;
    step();
    check("rbw_old_value", 32'(o_pred_taken), 32'd0);
    predict(32'h48);
    check("rbw_new_value", 32'(o_pred_taken), 32'd1);

    resolve(32'h50, 2'b01, 0, 1);
    check("pre_reset_pulse", 32'(o_mispredict), 32'd1);
    idle(); rst = 1; #1;
    check("reset_masks_pulse", 32'(o_mispredict), 32'd0);
    step();
    rst = 0;
    for (int i = 0; i < N; i++) begin
      predict(AW'(i * 4));
      check("reset_entry_not_taken", 32'(o_pred_taken), 32'd0);
    end
    resolve(32'h40, 2'b01, 1, 0);
    predict(32'h40);
    check("reset_entry_weak", 32'(o_pred_taken), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 149) == 0);
      pred_valid     = $urandom_range(0, 1);
      pred_pc        = $urandom;
      res_valid      = $urandom_range(0, 1);
      res_pc         = (c % 3 == 0) ? pred_pc : $urandom;
      res_op         = 2'($urandom_range(0, 3));
      res_taken      = $urandom_range(0, 1);
      res_pred_taken = $urandom_range(0, 1);
      step();
    end
    rst = 0; idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, number of history-table entries (power of 2, at least 2).
REQ-003 SHALL have localparam INDEX_WIDTH = $clog2(ENTRIES) and localparam OP_WIDTH = 2.
REQ-004 SHALL have port i_clk, input, 1, sole clock (rising edge).
REQ-005 SHALL have port i_rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port i_pred_valid, input, 1, fetch-side prediction request.
REQ-007 SHALL have port i_pred_pc, input, ADDR_WIDTH, PC of the fetched instruction.
REQ-008 SHALL have port o_pred_valid, output, 1, prediction response valid.
REQ-009 SHALL have port o_pred_taken, output, 1, predicted direction.
REQ-010 SHALL have port i_res_valid, input, 1, execute-side resolution strobe.
REQ-011 SHALL have port i_res_pc, input, ADDR_WIDTH, PC of the resolving instruction.
REQ-012 SHALL have port i_res_op, input, OP_WIDTH, compare op (00 NOP, 01 BEQ, 10 BLT, 11 BLE).
REQ-013 SHALL have port i_res_taken, input, 1, comparator outcome.
REQ-014 SHALL have port i_res_pred_taken, input, 1, direction that was predicted for this instruction.
REQ-015 SHALL have port o_mispredict, output, 1, one-cycle pulse on a wrong prediction.
REQ-016 SHALL have port o_redirect_taken, output, 1, actual direction accompanying o_mispredict.

Function
REQ-017 SHALL hold ENTRIES 2-bit saturating counters, indexed by pc[INDEX_WIDTH+1:2].
REQ-018 SHALL, one cycle after i_pred_valid=1, drive o_pred_valid=1 and o_pred_taken=counter[1] of the indexed entry, sampled at the request edge.
REQ-019 SHALL drive o_pred_valid=0 and o_pred_taken=0 in any cycle that follows a cycle with i_pred_valid=0.
REQ-020 SHALL, on i_res_valid=1 with i_res_op!=00, increment the indexed counter if i_res_taken=1 (saturating at 11) and decrement it otherwise (saturating at 00).
REQ-021 SHALL ignore resolutions with i_res_op=00: no counter update and no mispredict.
REQ-022 SHALL, one cycle after a counted resolution where i_res_taken!=i_res_pred_taken, drive o_mispredict=1 for exactly one cycle and o_redirect_taken=i_res_taken; otherwise drive both to 0.
REQ-023 SHALL, on a same-cycle predict and resolve to the same index, return the pre-update counter value (read-before-write).
REQ-024 SHALL accept back-to-back predictions and resolutions every cycle with no stall and no ready signal.
REQ-025 SHALL ignore PC bits [1:0] and bits above INDEX_WIDTH+1, so aliasing PCs share an entry.

Reset
REQ-026 SHALL, at the first rising edge with i_rst=1, set all counters to 01 (weakly not-taken) and drive o_pred_valid, o_pred_taken, o_mispredict and o_redirect_taken to 0.
REQ-027 SHALL, with i_rst=1, discard any same-cycle request or resolution, including any in-flight mispredict pulse.

Configuration
REQ-028 SHALL, when BRANCH_PREDICTOR_STATS_EN is defined, add output ports o_stat_branches (32 bits, counted resolutions) and o_stat_mispredicts (32 bits, mispredicts); both reset to 0, update one cycle after the resolution, and wrap modulo 2^32.
REQ-029 SHALL, when BRANCH_PREDICTOR_STATS_EN is undefined, omit those ports and their counters entirely, leaving all other behaviour unchanged.

Verification
REQ-030 SHALL cover a post-reset prediction: predict pc=0x40 -> o_pred_valid=1, o_pred_taken=0 one cycle later.
REQ-031 SHALL cover training: 2 resolutions at pc=0x40, op=01, taken=1 -> next predict at 0x40 returns taken=1; a 3rd and 4th resolution leave the counter saturated at 11.
REQ-032 SHALL cover a mispredict: resolve pc=0x44, op=10, taken=1, pred_taken=0 -> o_mispredict=1 and o_redirect_taken=1 for exactly one cycle.
REQ-033 SHALL cover a NOP resolution: op=00, taken=1, pred_taken=0 -> no mispredict and counter unchanged.
REQ-034 SHALL cover read-before-write: same-cycle predict and resolve (taken=1) at pc=0x48 from counter 01 -> prediction 0; a predict on the next cycle -> 1.
REQ-035 SHALL cover reset mid-operation: i_rst asserted the cycle after a mispredicting resolution -> o_mispredict stays 0, all entries return to 01, and stats (if enabled) read 0.
